// File: rtl/pwm_pkg.sv
// Shared mode encoding and width helpers for the multi-generator PWM block.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int sel_width(input int num_ch);
    return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
  endfunction

endpackage

// File: rtl/pwm_gen_core.sv
// One PWM timebase: power-of-two prescaler, edge/centre counter,
// shadowed period/duty registers and per-channel comparators.
module pwm_gen_core
  import pwm_pkg::*;
#(
  parameter int CH_PER_GEN = 2,
  parameter int CNT_W      = 8,
  parameter int PRESC_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        center,
  input  logic [PRESC_W-1:0]          prescale,
  input  logic [CNT_W-1:0]            period,
  input  logic [CH_PER_GEN*CNT_W-1:0] duty,
  input  logic                        update,
  output logic [CH_PER_GEN-1:0]       ch_raw,
  output logic                        period_tick,
  output logic                        update_pending
);

  localparam int PW = (1 << PRESC_W) - 1;

  logic [PW-1:0]               presc_q;
  logic [PW-1:0]               presc_lim;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_dn;
  logic [CNT_W-1:0]            period_q;
  logic [CH_PER_GEN*CNT_W-1:0] duty_q;
  logic                        dir_q;
  logic                        en_q;
  logic                        pending_q;
  logic                        tick_q;
  logic                        en_rise;
  logic                        step;
  logic                        going_down;
  logic                        boundary;
  logic                        load;

  // Limit is 2^p-1; a live decrease of p fires a step on the next compare.
  assign presc_lim  = {PW{1'b1}} >> (PW - int'(prescale));
  assign en_rise    = enable & ~en_q;
  assign step       = enable & en_q & (presc_q >= presc_lim);
  assign cnt_dn     = cnt_q - CNT_W'(1);
  assign going_down = dir_q | (cnt_q >= period_q);

  always_comb begin
    boundary = 1'b0;
    if (step) begin
      if (period_q == '0)          boundary = 1'b1;
      else if (center == MODE_EDGE) boundary = (cnt_q >= period_q);
      else                          boundary = going_down & (cnt_dn == '0);
    end
  end

  assign load = en_rise | (boundary & (pending_q | update));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      cnt_q     <= '0;
      period_q  <= '0;
      duty_q    <= '0;
      dir_q     <= 1'b0;
      en_q      <= 1'b0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      en_q   <= enable;
      tick_q <= boundary;
      if (load) begin
        period_q  <= period;
        duty_q    <= duty;
        pending_q <= 1'b0;
      end else if (update) begin
        pending_q <= 1'b1;
      end
      if (!enable || en_rise) begin
        presc_q <= '0;
        cnt_q   <= '0;
        dir_q   <= 1'b0;
      end else begin
        presc_q <= step ? '0 : presc_q + PW'(1);
        if (step) begin
          if (period_q == '0 || boundary) begin
            cnt_q <= '0;
            dir_q <= 1'b0;
          end else if (center == MODE_CENTER && going_down) begin
            cnt_q <= cnt_dn;
            dir_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  for (genvar c = 0; c < CH_PER_GEN; c++) begin : g_cmp
    assign ch_raw[c] = enable & en_q & (cnt_q < duty_q[c*CNT_W +: CNT_W]);
  end

  assign period_tick    = tick_q;
  assign update_pending = pending_q;

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-generator PWM peripheral: NUM_GEN timebases feeding a registered
// per-pin routing mux with static-level and invert control.
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int  NUM_GEN    = 2,
  parameter int  CH_PER_GEN = 2,
  parameter int  CNT_W      = 8,
  parameter int  PRESC_W    = 4,
  parameter int  NUM_OUT    = 8,
  localparam int NUM_CH     = NUM_GEN * CH_PER_GEN,
  localparam int SEL_W      = sel_width(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_GEN-1:0]         gen_enable,
  input  logic [NUM_GEN-1:0]         gen_center,
  input  logic [NUM_GEN*PRESC_W-1:0] gen_prescale,
  input  logic [NUM_GEN*CNT_W-1:0]   gen_period,
  input  logic [NUM_CH*CNT_W-1:0]    ch_duty,
  input  logic [NUM_GEN-1:0]         gen_update,
  input  logic [NUM_OUT-1:0]         out_en,
  input  logic [NUM_OUT-1:0]         out_pwm_en,
  input  logic [NUM_OUT*SEL_W-1:0]   out_sel,
  input  logic [NUM_OUT-1:0]         out_invert,
  output logic [NUM_OUT-1:0]         out,
  output logic [NUM_GEN-1:0]         period_tick,
  output logic [NUM_GEN-1:0]         update_pending
);

  logic [NUM_CH-1:0]  ch_raw;
  logic [NUM_OUT-1:0] routed;
  logic [NUM_OUT-1:0] pin_d;

  for (genvar g = 0; g < NUM_GEN; g++) begin : g_gen
    pwm_gen_core #(
      .CH_PER_GEN (CH_PER_GEN),
      .CNT_W      (CNT_W),
      .PRESC_W    (PRESC_W)
    ) u_core (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (gen_enable[g]),
      .center         (gen_center[g]),
      .prescale       (gen_prescale[g*PRESC_W +: PRESC_W]),
      .period         (gen_period[g*CNT_W +: CNT_W]),
      .duty           (ch_duty[g*CH_PER_GEN*CNT_W +: CH_PER_GEN*CNT_W]),
      .update         (gen_update[g]),
      .ch_raw         (ch_raw[g*CH_PER_GEN +: CH_PER_GEN]),
      .period_tick    (period_tick[g]),
      .update_pending (update_pending[g])
    );
  end

  // Selects beyond NUM_CH match no channel and route a constant 0.
  always_comb begin
    routed = '0;
    pin_d  = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (out_sel[i*SEL_W +: SEL_W] == SEL_W'(j)) routed[i] = ch_raw[j];
      end
      pin_d[i] = (out_en[i] & out_pwm_en[i]) ? (routed[i] ^ out_invert[i]) : out_en[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else        out <= pin_d;
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Scoreboard bench for pwm_multi_gen: a closed-form timebase model pushes the
// expected pins/ticks/pending per clock, a monitor pops and compares.
module tb_pwm_multi_gen;

  localparam int NG = 2, CPG = 2, CW = 8, PWID = 4, NO = 8, NCH = 4, SW = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NG-1:0]      gen_enable, gen_center, gen_update;
  logic [NG*PWID-1:0] gen_prescale;
  logic [NG*CW-1:0]   gen_period;
  logic [NCH*CW-1:0]  ch_duty;
  logic [NO-1:0]      out_en, out_pwm_en, out_invert, out;
  logic [NO*SW-1:0]   out_sel;
  logic [NG-1:0]      period_tick, update_pending;

  always #5 clk = ~clk;

  pwm_multi_gen dut (
    .clk(clk), .rst_n(rst_n), .gen_enable(gen_enable), .gen_center(gen_center),
    .gen_prescale(gen_prescale), .gen_period(gen_period), .ch_duty(ch_duty),
    .gen_update(gen_update), .out_en(out_en), .out_pwm_en(out_pwm_en),
    .out_sel(out_sel), .out_invert(out_invert), .out(out),
    .period_tick(period_tick), .update_pending(update_pending)
  );

  typedef struct {
    string         tag;
    logic [NO-1:0] pins;
    logic [NG-1:0] tick;
    logic [NG-1:0] pend;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        n_cmp = 0;
  int        n_err = 0;
  string     cur_tag = "idle";

  // model state per generator: edges since (re)start, active period/duty
  int mj[NG], mp[NG], m_per[NG];
  int m_duty[NG][CPG];
  bit men[NG], mpend[NG], mctr[NG];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_at(input int s, input int per, input bit ctr);
    int ph;
    if (per == 0) return 0;
    if (!ctr) return s % (per + 1);
    ph = s % (2 * per);
    return (ph <= per) ? ph : 2 * per - ph;
  endfunction

  function automatic bit is_bnd(input int jn, input int p, input int per, input bit ctr);
    int s;
    if ((jn % (1 << p)) != 0) return 1'b0;
    s = jn >> p;
    if (per == 0) return 1'b1;
    return ctr ? ((s % (2 * per)) == 0) : ((s % (per + 1)) == 0);
  endfunction

  task automatic load_gen(input int g);
    mp[g]    = int'(gen_prescale[g*PWID +: PWID]);
    m_per[g] = int'(gen_period[g*CW +: CW]);
    mctr[g]  = gen_center[g];
    for (int c = 0; c < CPG; c++) m_duty[g][c] = int'(ch_duty[(g*CPG+c)*CW +: CW]);
  endtask

  // Called at a negedge with this cycle's inputs driven; predicts the state
  // seen just after the coming posedge, then advances to the next negedge.
  task automatic cycle();
    sb_entry_t     e;
    logic [NCH-1:0] raw;
    int            jn;
    bit            bnd;
    raw    = '0;
    e.tag  = cur_tag;
    e.tick = '0;
    e.pend = '0;
    for (int g = 0; g < NG; g++) begin
      if (!gen_enable[g]) begin
        men[g] = 1'b0;
        mj[g]  = 0;
        if (gen_update[g]) mpend[g] = 1'b1;
      end else if (!men[g]) begin
        load_gen(g);
        men[g]   = 1'b1;
        mj[g]    = 0;
        mpend[g] = 1'b0;
      end else begin
        for (int c = 0; c < CPG; c++)
          raw[g*CPG+c] = cnt_at(mj[g] >> mp[g], m_per[g], mctr[g]) < m_duty[g][c];
        jn        = mj[g] + 1;
        bnd       = is_bnd(jn, mp[g], m_per[g], mctr[g]);
        e.tick[g] = bnd;
        if (bnd && (mpend[g] || gen_update[g])) begin
          load_gen(g);
          mj[g]    = 0;
          mpend[g] = 1'b0;
        end else begin
          mj[g] = jn;
          if (gen_update[g]) mpend[g] = 1'b1;
        end
      end
      e.pend[g] = mpend[g];
    end
    // pins: 0-3 follow channels 0-3, 4 static high, 5 static low, 6/7 inverted ch0/ch3
    e.pins = {~raw[3], ~raw[0], 1'b0, 1'b1, raw[3:0]};
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    sb_entry_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_val({e.tag, "_out"},  32'(out),            32'(e.pins));
        check_val({e.tag, "_tick"}, 32'(period_tick),    32'(e.tick));
        check_val({e.tag, "_pend"}, 32'(update_pending), 32'(e.pend));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    rst_n        = 1'b0;
    gen_enable   = '0;
    gen_center   = 2'b10;
    gen_update   = '0;
    gen_prescale = {4'd2, 4'd0};
    gen_period   = {8'd4, 8'd9};
    ch_duty      = {8'd3, 8'd2, 8'd0, 8'd3};
    out_en       = 8'b1101_1111;
    out_pwm_en   = 8'b1100_1111;
    out_invert   = 8'b1100_0000;
    out_sel      = {2'd3, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    for (int g = 0; g < NG; g++) begin
      mj[g] = 0; men[g] = 1'b0; mpend[g] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check_val("reset_out",  32'(out),            32'h0);
    check_val("reset_tick", 32'(period_tick),    32'h0);
    check_val("reset_pend", 32'(update_pending), 32'h0);
    rst_n = 1'b1;

    cur_tag = "idle";
    repeat (3) cycle();

    // gen0 edge p=0 P=9 D=3/0; gen1 centre p=2 P=4 D=2/3
    gen_enable = 2'b11;
    cur_tag    = "run";
    repeat (70) cycle();

    cur_tag = "align";
    for (int k = 0; k < 20; k++) begin
      if ((mj[0] % 10) == 4) break;
      cycle();
    end
    ch_duty[7:0]  = 8'd7;
    gen_update[0] = 1'b1;
    cur_tag       = "shadow";
    cycle();
    gen_update[0] = 1'b0;
    repeat (25) cycle();

    ch_duty[7:0]  = 8'd12;
    gen_update[0] = 1'b1;
    cur_tag       = "duty_max";
    cycle();
    gen_update[0] = 1'b0;
    repeat (25) cycle();

    gen_period[7:0] = 8'd0;
    gen_update[0]   = 1'b1;
    cur_tag         = "period0";
    cycle();
    gen_update[0] = 1'b0;
    repeat (12) cycle();

    // with P=0 every step is a boundary, so the update lands on one
    ch_duty[7:0]  = 8'd0;
    gen_update[0] = 1'b1;
    cur_tag       = "coincident";
    cycle();
    gen_update[0] = 1'b0;
    repeat (5) cycle();

    gen_enable[1] = 1'b0;
    cur_tag       = "disabled";
    repeat (4) cycle();
    gen_update[1] = 1'b1;
    cycle();
    gen_update[1] = 1'b0;
    repeat (3) cycle();
    gen_enable[1] = 1'b1;
    cur_tag       = "reenable";
    repeat (10) cycle();

    gen_period[7:0] = 8'd9;
    ch_duty[7:0]    = 8'd3;
    gen_update      = 2'b11;
    cur_tag         = "pre_reset";
    cycle();
    gen_update = 2'b00;
    for (int k = 0; k < 30; k++) begin
      if (mj[0] == 5) break;
      cycle();
    end
    check_val("pre_reset_cnt5", 32'(mj[0]), 32'd5);

    rst_n = 1'b0;
    #1;
    check_val("midrst_out",  32'(out),            32'h0);
    check_val("midrst_tick", 32'(period_tick),    32'h0);
    check_val("midrst_pend", 32'(update_pending), 32'h0);
    for (int g = 0; g < NG; g++) begin
      mj[g] = 0; men[g] = 1'b0; mpend[g] = 1'b0;
    end
    @(negedge clk);
    rst_n   = 1'b1;
    cur_tag = "restart";
    repeat (25) cycle();

    @(posedge clk);
    #2;
    check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
- Parametrised multi-generator PWM peripheral; next generation of the fixed 2-generator, 8-output PWM block behind the SPI register file.
- Adds per-generator programmable period, edge- or centre-aligned counting, and exact power-of-two prescaling.
- Adds double-buffered (shadow) period/duty registers that load only at period boundaries, plus per-pin polarity invert.
- Outputs are registered. A per-pin routing mux selects any generator channel.

Parameters:
- NUM_GEN, 2, number of independent generators (timebases).
- CH_PER_GEN, 2, compare channels per generator.
- CNT_W, 8, counter/period/duty width in bits.
- PRESC_W, 4, prescale exponent width; divide = 2^prescale.
- NUM_OUT, 8, number of output pins.
- Derived: NUM_CH = NUM_GEN*CH_PER_GEN.
- Derived: SEL_W = max(1, clog2(NUM_CH)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- gen_enable  in  NUM_GEN  run enable per generator.
- gen_center  in  NUM_GEN  1 = centre-aligned (up/down), 0 = edge-aligned (up, wrap).
- gen_prescale  in  NUM_GEN*PRESC_W  prescale exponent per generator.
- gen_period  in  NUM_GEN*CNT_W  shadow period per generator.
- ch_duty  in  NUM_CH*CNT_W  shadow duty. Channel index is g*CH_PER_GEN+c.
- gen_update  in  NUM_GEN  single-cycle pulse; arms a shadow load.
- out_en  in  NUM_OUT  pin drive level / enable.
- out_pwm_en  in  NUM_OUT  pin uses PWM when set together with out_en.
- out_sel  in  NUM_OUT*SEL_W  channel routed to each pin.
- out_invert  in  NUM_OUT  invert the PWM value on the pin.
- out  out  NUM_OUT  registered pin outputs.
- period_tick  out  NUM_GEN  one-cycle pulse at each period boundary.
- update_pending  out  NUM_GEN  shadow load armed, not yet taken.

Behaviour:
- Reset: all counters, prescalers and active registers are 0. out = 0, period_tick = 0, update_pending = 0.
- Prescaler: counts 0..2^p-1 and emits a step when at 2^p-1, giving exactly one step per 2^p clocks. p = 0 steps every clock.
  - p is sampled live. If the counter is already ≥ 2^p-1 after p decreases, a step fires and the counter clears.
- Edge mode: cnt runs 0,1..P_act,0. Period = P_act+1 steps. The boundary is the step where cnt wraps P_act→0.
- Centre mode: cnt runs 0 up to P_act, then down to 1, then 0. Period = 2*P_act steps. The boundary is the step where cnt reaches 0 while counting down. Direction flips at P_act and at 0.
- P_act = 0 in either mode: cnt holds at 0 and every step is a boundary.
- Compare: ch_raw = (cnt < D_act), unsigned CNT_W compare.
  - D_act = 0 gives constant 0.
  - D_act > P_act gives constant 1.
- Shadow load:
  - gen_update sets update_pending.
  - At a boundary step with update_pending = 1, P_act and all D_act of that generator load the live inputs of that cycle, and update_pending clears. The load applies to the next period.
  - gen_update coincident with a boundary: the load happens at that boundary and pending ends at 0.
- gen_enable = 0:
  - cnt, prescaler and direction are held at reset values.
  - ch_raw is forced to 0 and period_tick = 0.
  - update_pending is preserved.
- gen_enable rising edge: P_act/D_act load immediately, pending clears, and counting starts next cycle from cnt = 0.
- period_tick: asserted in the cycle after the boundary step, for one clock.
- Output mux, per pin i, registered (1-cycle latency from ch_raw):
  - If out_en[i] & out_pwm_en[i]: out[i] <= ch_raw[out_sel[i]] ^ out_invert[i].
  - Otherwise: out[i] <= out_en[i].
  - out_sel ≥ NUM_CH selects constant 0 before the invert.
- Reset asserted mid-period: everything clears immediately and asynchronously. No partial period resumes.

Decomposition:
- Package pwm_pkg:
  - clog2 function.
  - localparams for mode encoding (MODE_EDGE = 0, MODE_CENTER = 1).
  - SEL_W derivation helper.
- Sub-module pwm_gen_core (one generator: prescaler, up/down counter, shadow/active registers, CH_PER_GEN comparators), instantiated NUM_GEN times by generate.
- The top level holds the pin mux and output registers.

Test Plan:
- Edge-mode duty. Gen0 edge, p = 0, period = 9, duty = 3, gen_enable 0→1 -> pin pattern high 3 / low 7 clocks, repeating every 10 clocks; period_tick every 10 clocks.
- Centre mode with prescale. Gen1 centre, p = 2, period = 4, duty = 2 -> period 32 clocks; high while cnt ∈ {0,1}, i.e. a centred pattern, symmetric in time.
- Shadow timing. Running duty = 3 / period = 9; set duty = 7 and pulse gen_update mid-period -> current period keeps 3; the next period shows 7; update_pending drops at the boundary.
- Extremes. duty = 0 -> constant 0; duty = 12 with period = 9 -> constant 1; out_invert = 1 -> complement of both; period = 0 -> tick every step.
- Pin mux and static levels. out_en = 1, out_pwm_en = 0 -> pin = 1; out_en = 0 -> pin = 0; out_sel = 3 -> pin follows gen1 ch1; disabled generator -> routed pin = 0 (1 if inverted).
- Reset mid-run. Assert rst_n = 0 while cnt = 5 -> out, period_tick and update_pending are 0 immediately; after release with gen_enable held high, the period restarts from cnt = 0.
